// File: rtl/mem_stage_cache_if.sv
// Request/ready bus between the data cache and the multi-cycle backing memory.
// The master side is the cache; the slave side is the memory model or controller.
interface mem_stage_cache_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_stage_cache.sv
// RV32I memory stage: direct-mapped write-back/write-allocate data cache with
// miss stall, load/store lane handling and hit/miss counters.
//
//   state | meaning
//   IDLE  | serve hits; a miss raises Stall and picks WB or FILL
//   WB    | write the dirty victim line back, wait for mem_ready
//   FILL  | fetch the missing word, wait for mem_ready, then replay in IDLE
module mem_stage_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  ResultSrc,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Stall,
  mem_stage_cache_if.master     mem,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = DATA_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t state, state_nx;

  logic [SETS-1:0]       valid, dirty;
  logic [TAGW-1:0]       tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS];

  logic [IDX-1:0]        index;
  logic [TAGW-1:0]       tag;
  logic [TAGW-1:0]       line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  access, hit;

  logic                  hit_ev, miss_ev, store_hit, wb_done, fill_done;
  logic                  req, we;
  logic [DATA_WIDTH-1:0] addr, wdata;
  logic [DATA_WIDTH-1:0] st_word, ld_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign index     = ALUResult[IDX+1:2];
  assign tag       = ALUResult[DATA_WIDTH-1:IDX+2];
  assign line_tag  = tag_mem[index];
  assign line_data = data_mem[index];
  assign access    = MemRead | MemWrite;
  assign hit       = valid[index] && (line_tag == tag);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    Stall     = 1'b0;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    store_hit = 1'b0;
    wb_done   = 1'b0;
    fill_done = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    case (state)
      IDLE: begin
        if (access) begin
          if (hit) begin
            hit_ev    = 1'b1;
            store_hit = MemWrite;
          end else begin
            Stall    = 1'b1;
            miss_ev  = 1'b1;
            state_nx = (valid[index] && dirty[index]) ? WB : FILL;
          end
        end
      end
      WB: begin
        Stall = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        addr  = {line_tag, index, 2'b00};
        wdata = line_data;
        if (mem.mem_ready) begin
          wb_done  = 1'b1;
          state_nx = FILL;
        end
      end
      FILL: begin
        Stall = 1'b1;
        req   = 1'b1;
        addr  = {tag, index, 2'b00};
        if (mem.mem_ready) begin
          fill_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Upstream must never be frozen while the stage is being reset.
    if (rst) Stall = 1'b0;
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      dirty    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_ev)    hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
      if (miss_ev)   miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      if (store_hit) dirty[index] <= 1'b1;
      if (wb_done)   dirty[index] <= 1'b0;
      if (fill_done) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (!rst && store_hit) data_mem[index] <= st_word;
    if (!rst && fill_done) begin
      data_mem[index] <= mem.mem_rdata;
      tag_mem[index]  <= tag;
    end
  end

  always_comb begin
    st_word = line_data;
    case (funct3[1:0])
      2'b00:   st_word[{ALUResult[1:0], 3'b000} +: 8]  = WriteData[7:0];
      2'b01:   st_word[{ALUResult[1], 4'b0000} +: 16] = WriteData[15:0];
      default: st_word = WriteData;
    endcase
  end

  assign ld_byte = line_data[{ALUResult[1:0], 3'b000} +: 8];
  assign ld_half = line_data[{ALUResult[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      3'b000:  ld_word = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_word = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_word = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_word = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_word = line_data;
    endcase
  end

  assign Result = ResultSrc ? ld_word : ALUResult;

endmodule

// File: tb/tb_mem_stage_cache.sv
// Randomized bench for mem_stage_cache: a behavioural cache/memory model
// predicts hits, write-backs, fills, stall length, results and counters.
module tb_mem_stage_cache;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] ALUResult, WriteData, Result;
  logic        ResultSrc, MemWrite, MemRead, Stall;
  logic [2:0]  funct3;
  logic [31:0] hit_cnt, miss_cnt;

  mem_stage_cache_if mbus ();

  mem_stage_cache dut (
    .clk       (clk),
    .rst       (rst),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ResultSrc (ResultSrc),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .funct3    (funct3),
    .Result    (Result),
    .Stall     (Stall),
    .mem       (mbus),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory contents: unwritten words take a fixed hash of their address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          fixed_wait = -1;
  bit          hold_ready = 1'b0;
  bit          log_we   [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          log_wait [$];

  initial begin : responder
    bit busy;
    int wl, used;
    busy = 1'b0;
    wl   = 0;
    used = 0;
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mbus.mem_ready = 1'b0;
      mbus.mem_rdata = $urandom();
      if (hold_ready || rst) begin
        busy = 1'b0;
      end else if (mbus.mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wl   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          used = wl;
        end
        if (wl == 0) begin
          busy = 1'b0;
          mbus.mem_ready = 1'b1;
          log_we.push_back(mbus.mem_we);
          log_addr.push_back(mbus.mem_addr);
          log_wait.push_back(used);
          if (mbus.mem_we) begin
            env_mem[mbus.mem_addr] = mbus.mem_wdata;
            log_data.push_back(mbus.mem_wdata);
          end else begin
            mbus.mem_rdata = env_mem.exists(mbus.mem_addr) ? env_mem[mbus.mem_addr]
                                                           : init_word(mbus.mem_addr);
            log_data.push_back(mbus.mem_rdata);
          end
        end else begin
          wl--;
        end
      end else begin
        mbus.mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  bit          m_valid [64];
  bit          m_dirty [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] m_hits, m_misses;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [31:0] a,
                                            input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] m;
    int s;
    if (f3[1:0] == 2'd0) begin
      m = 32'hFF;   s = 8 * a[1:0];
    end else if (f3[1:0] == 2'd1) begin
      m = 32'hFFFF; s = 16 * a[1];
    end else begin
      return wd;
    end
    return (w & ~(m << s)) | ((wd & m) << s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = '0;
    m_misses = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ResultSrc = 1'b0;
    @(negedge clk);
    check("stall_in_reset", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    check("rst_mem_req", 32'(mbus.mem_req), 32'd0);
    check("rst_mem_we", 32'(mbus.mem_we), 32'd0);
    check("rst_mem_addr", mbus.mem_addr, 32'd0);
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit rsrc,
                        output logic [31:0] res);
    int idx, cyc, exp_cyc;
    logic [23:0] tg;
    bit acc, exp_hit, exp_wb, miss;
    logic [31:0] vict_addr, vict_data, exp_res;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = wd; ResultSrc = rsrc;
    idx       = int'(a[7:2]);
    tg        = a[31:8];
    acc       = rd | wr;
    exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
    miss      = acc && !exp_hit;
    exp_wb    = miss && m_valid[idx] && m_dirty[idx];
    vict_addr = {m_tag[idx], a[7:2], 2'b00};
    vict_data = m_data[idx];
    log_we.delete(); log_addr.delete(); log_data.delete(); log_wait.delete();
    @(negedge clk);
    check("stall_first", 32'(Stall), 32'(miss));
    cyc = 0;
    while (Stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    if (Stall) check("stall_timeout", 32'd1, 32'd0);
    if (miss) begin
      if (exp_wb) ref_mem[vict_addr] = vict_data;
      m_data[idx]  = ref_read({a[31:2], 2'b00});
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_misses++;
    end
    if (acc) m_hits++;
    exp_res = rsrc ? load_val(m_data[idx], a, f3) : a;
    res = Result;
    check("result", Result, exp_res);
    exp_cyc = miss ? 1 : 0;
    foreach (log_wait[i]) exp_cyc += log_wait[i] + 1;
    check("stall_cycles", 32'(cyc), 32'(exp_cyc));
    check("txn_count", 32'(log_we.size()), miss ? (exp_wb ? 32'd2 : 32'd1) : 32'd0);
    if (exp_wb && log_we.size() >= 1) begin
      check("wb_we", 32'(log_we[0]), 32'd1);
      check("wb_addr", log_addr[0], vict_addr);
      check("wb_data", log_data[0], vict_data);
    end
    if (miss && log_we.size() >= 1) begin
      check("fill_we", 32'(log_we[log_we.size()-1]), 32'd0);
      check("fill_addr", log_addr[log_addr.size()-1], {a[31:2], 2'b00});
    end
    if (wr) begin
      m_data[idx]  = store_val(m_data[idx], a, f3, wd);
      m_dirty[idx] = 1'b1;
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; ResultSrc = 1'b0;
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] r;
    int kind;
    bit rd, wr, rs;
    logic [2:0] f3;
    logic [31:0] a;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ResultSrc = 1'b0;
    funct3 = 3'b010; ALUResult = '0; WriteData = '0;
    repeat (2) @(posedge clk);
    do_reset();

    env_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    fixed_wait = 3;
    access(1, 0, 3'b010, 32'h100, 0, 1, r);
    check("cold_lw", r, 32'hDEADBEEF);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd1);
    fixed_wait = -1;

    access(0, 1, 3'b000, 32'h101, 32'h55, 0, r);
    access(1, 0, 3'b010, 32'h100, 0, 1, r);
    check("sb_lw", r, 32'hDEAD55EF);
    access(1, 0, 3'b100, 32'h101, 0, 1, r);
    check("lbu", r, 32'h00000055);
    access(1, 0, 3'b000, 32'h103, 0, 1, r);
    check("lb", r, 32'hFFFFFFDE);

    access(1, 0, 3'b010, 32'h200, 0, 1, r);
    check("dirty_txns", 32'(log_we.size()), 32'd2);
    if (log_we.size() == 2) begin
      check("dirty_wb_addr", log_addr[0], 32'h100);
      check("dirty_wb_data", log_data[0], 32'hDEAD55EF);
      check("dirty_fill_addr", log_addr[1], 32'h200);
    end

    access(0, 1, 3'b010, 32'h100, 32'h80017FFF, 0, r);
    check("clean_txns", 32'(log_we.size()), 32'd1);
    access(1, 0, 3'b001, 32'h102, 0, 1, r);
    check("lh_hi", r, 32'hFFFF8001);
    access(1, 0, 3'b101, 32'h102, 0, 1, r);
    check("lhu_hi", r, 32'h00008001);
    access(1, 0, 3'b001, 32'h100, 0, 1, r);
    check("lh_lo", r, 32'h00007FFF);

    access(0, 0, 3'b000, 32'h12345678, 0, 0, r);
    check("non_mem", r, 32'h12345678);

    // Abandon a fill with reset, then the same load must miss again.
    do_reset();
    hold_ready = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h100; ResultSrc = 1'b1;
    @(negedge clk);
    check("rf_stall", 32'(Stall), 32'd1);
    @(negedge clk);
    check("rf_req", 32'(mbus.mem_req), 32'd1);
    check("rf_we", 32'(mbus.mem_we), 32'd0);
    check("rf_addr", mbus.mem_addr, 32'h100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rf_stall_rst", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0; ResultSrc = 1'b0; hold_ready = 1'b0;
    check("rf_req_drop", 32'(mbus.mem_req), 32'd0);
    model_clear();
    access(1, 0, 3'b010, 32'h100, 0, 1, r);
    check("rf_remiss_cnt", miss_cnt, 32'd1);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      a = {22'(0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      a = {a[31:10], a[9:8], 2'b00, a[5:0]};
      rd = (kind >= 1 && kind <= 5) || kind == 9;
      wr = kind >= 6;
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      rs = (kind == 0) ? 1'b0 : (rd && !wr) ? 1'b1 : 1'($urandom_range(0, 1));
      access(rd, wr, f3, a, $urandom(), rs, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_cache.md
# mem_stage_cache

Parametrised memory stage for the RV32I core. It puts a direct-mapped, write-back, write-allocate data cache in front of a multi-cycle backing memory. On any miss it stalls the pipeline through a request/ready handshake. It keeps the load/store byte-lane handling (funct3) and the ALUResult/ReadData result select of the single-cycle memory stage, and adds hit/miss performance counters.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; fixed at 32 for RV32I lane logic
- SETS, 64, cache lines, one word per line; power of two; IDX = log2(SETS)
- CNT_WIDTH, 32, width of the hit and miss counters

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- ALUResult  in  DATA_WIDTH  byte address for accesses; ALU value for non-memory results
- WriteData  in  DATA_WIDTH  store data (rs2)
- ResultSrc  in  1  0 selects ALUResult, 1 selects load data
- MemWrite  in  1  store request
- MemRead  in  1  load request
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Result  out  DATA_WIDTH  stage result
- Stall  out  1  freezes the upstream pipeline; all inputs must stay stable while it is high
- mem_req  out  1  backing-memory request
- mem_we  out  1  1 = write-back, 0 = fill
- mem_addr  out  DATA_WIDTH  word-aligned backing address
- mem_wdata  out  DATA_WIDTH  write-back data
- mem_rdata  in  DATA_WIDTH  fill data, valid when mem_ready=1
- mem_ready  in  1  completes the current request
- hit_cnt  out  CNT_WIDTH  accesses that hit in IDLE
- miss_cnt  out  CNT_WIDTH  misses detected

## Operation
Address fields and access:
- Index = ALUResult[IDX+1:2]; tag = ALUResult[31:IDX+2].
- Each line holds a valid bit, a dirty bit, the tag and one data word. Only the valid and dirty bits are reset.
- access = MemRead | MemWrite.
- hit = valid[index] & (tag matches).
- If MemRead and MemWrite are both high, the access is a store.

FSM states are IDLE, WB and FILL.
- **IDLE, access and hit:**
  - Stall=0.
  - Load: byte lane selected by ALUResult[1:0]; halfword selected by ALUResult[1], with ALUResult[0] ignored.
  - Sign- or zero-extend per funct3. Codes 011/110/111 return the full word.
  - Store: at the clock edge, merge the byte (SB), half (SH) or word (SW) into the line and set dirty.
  - hit_cnt increments.
- **IDLE, access and miss:**
  - Stall=1 combinationally in the same cycle; miss_cnt increments once.
  - Next state is WB if the victim line is valid and dirty, otherwise FILL.
- **WB:**
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data.
  - Hold until mem_ready, then go to FILL and clear dirty.
- **FILL:**
  - Drive mem_req=1, mem_we=0, mem_addr={tag, index, 2'b00}.
  - On mem_ready, the line takes mem_rdata, valid=1, dirty=0 and the new tag; go to IDLE.
- **Replay:** back in IDLE the held access now hits and completes as above, including hit_cnt. A miss therefore counts one miss and one hit.
- **Result:** ResultSrc=0 gives Result=ALUResult. ResultSrc=1 gives the extended load data.
- **Stall:** high in every WB and FILL cycle. In IDLE it is high only on an access miss.
- **Counters:** wrap modulo 2^CNT_WIDTH.

## Timing
- **Reset values:** state=IDLE, all valid=0, all dirty=0, hit_cnt=0, miss_cnt=0, mem_req=0, mem_we=0.
  - mem_addr and mem_wdata are 0 while not requesting.
  - While rst=1, Stall=0. Result stays combinational.
- **Handshake:**
  - mem_req is a registered state decode, so it rises one cycle after the miss is detected.
  - mem_req, mem_we, mem_addr and mem_wdata hold stable until the cycle in which mem_ready=1 is sampled.
  - mem_ready is ignored while mem_req=0.
  - mem_ready may be high in the first request cycle, giving zero wait.
- **Latency:**
  - A hit takes 0 stall cycles.
  - A clean miss stalls 1 + F cycles, where F is the FILL cycles including the ready cycle.
  - A dirty miss stalls 1 + W + F cycles, where W is the WB cycles.
  - The replay hit happens in the cycle after the FILL handshake completes.
- **Reset mid-transaction:** rst in WB or FILL abandons the transaction. mem_req=0 from the next cycle, and the interrupted line is left invalid.
- **Data path:** the array read is combinational (distributed RAM); writes occur at the edge.

## Test plan
- **Cold miss:** reset, then LW 0x100 → Stall=1 at once; mem_req=1, mem_we=0, mem_addr=0x100 next cycle. mem_ready after 3 cycles with 0xDEADBEEF → next cycle Stall=0, Result=0xDEADBEEF, miss_cnt=1, hit_cnt=1.
- **Store hit and lane extraction:** SB 0x101 with WriteData 0x55 → no stall. Then LW 0x100 → 0xDEAD55EF, LBU 0x101 → 0x00000055, LB 0x103 → 0xFFFFFFDE.
- **Conflict miss on a dirty line:** after the store scenario, LW 0x200 (same index) → WB with mem_addr=0x100, mem_wdata=0xDEAD55EF, then FILL with mem_addr=0x200. No write-back occurs if the line is clean.
- **Halfword extension:** line holds 0x80017FFF; LH 0x102 → 0xFFFF8001, LHU 0x102 → 0x00008001, LH 0x100 → 0x00007FFF.
- **Non-memory op:** ResultSrc=0, MemRead=MemWrite=0, ALUResult=0x12345678 → Result=0x12345678, Stall=0, counters unchanged.
- **Reset during FILL:** assert rst in FILL → mem_req=0 next cycle. A later LW 0x100 misses again and miss_cnt restarts from 1.
